rr_arb_chk: RTL and testbench



---
 rtl/rr_arb_chk_pkg.sv | 29 ++
 rtl/rr_arb_chk_if.sv | 33 +++
 rtl/rr_arb_chk_rr_pick.sv | 36 +++
 rtl/rr_arb_chk.sv | 150 +++++++++++++++
 tb/tb_rr_arb_chk.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_chk_pkg.sv
// Shared types, defaults and helpers for the rr_arb_chk round-robin arbiter.
// Contents:
//   arb_state_t   - arbiter FSM state encoding {IDLE, BUSY}
//   DEF_*         - default parameter values
//   WAIT_W        - width of the per-requester wait counters
//   onehot_to_idx - one-hot (up to 32 bits) to binary index
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_N        = 4;
    localparam int unsigned DEF_MAX_WAIT = 15;
    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned WAIT_W       = 8;

    // OR-reduces the indices of set bits; exact for one-hot, 0 for all-zero.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_chk_if.sv
// Request/grant bundle between N bus masters and the rr_arb_chk arbiter.
// Signals:
//   req        - per-requester level request (driven by masters)
//   gnt        - registered one-hot-or-zero grant
//   gnt_vld    - any grant active
//   gnt_id     - index of the granted requester, 0 when idle
//   starve     - per-requester starvation flag
//   starve_cnt - saturating count of starvation events
// Modports: master (requesters / bench), slave (arbiter).
interface rr_arb_chk_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_id;
    logic [N-1:0]     starve;
    logic [CNT_W-1:0] starve_cnt;

    modport master (
        output req,
        input  gnt, gnt_vld, gnt_id, starve, starve_cnt
    );

    modport slave (
        input  req,
        output gnt, gnt_vld, gnt_id, starve, starve_cnt
    );

endinterface

// File: rtl/rr_arb_chk_rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Ports:
//   req    - request vector
//   start  - index with highest priority; search wraps modulo N
//   winner - one-hot winner (zero when no request)
//   valid  - any request present
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic [N-1:0]   winner,
    output logic           valid
);

    int unsigned idx;
    logic        found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/rr_arb_chk.sv
// rr_arb_chk: N-way round-robin arbiter with grant locking, per-requester
// starvation detection and a saturating starvation-event counter.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - rr_arb_chk_if.slave (req in; gnt, gnt_vld, gnt_id, starve, starve_cnt out)
// Optional build macro: ARB_ASSERT_EN compiles in immediate assertions on the
// grant vector and starvation warnings; functional outputs are unchanged.
module rr_arb_chk
    import arb_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input logic         clk,
    input logic         rst,
    rr_arb_chk_if.slave bus
);

    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_BUSY = BUSY;
    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

    logic [0:0]       state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             gnt_vld_q;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   start;
    logic [N-1:0]     pick_req, pick_gnt;
    logic             pick_vld;
    logic             owner_req;
    logic [WAIT_W-1:0] wait_q [N];
    logic [WAIT_W-1:0] wait_d [N];
    logic [N-1:0]     starve, starve_prev_q, starve_rise;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Search always begins just after the last owner; the outgoing owner is
    // masked so it can only win after a full rotation.
    assign start    = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
    assign pick_req = (state_q == ST_BUSY) ? (bus.req & ~gnt_q) : bus.req;
    assign owner_req = |(bus.req & gnt_q);

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (pick_req),
        .start  (start),
        .winner (pick_gnt),
        .valid  (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_gnt;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    if (pick_vld) begin
                        gnt_d = pick_gnt;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        gnt_id_d = IDW'(onehot_to_idx(32'(gnt_d)));
        ptr_d    = (|gnt_d) ? gnt_id_d : ptr_q;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            wait_d[i] = '0;
            if (bus.req[i] && !gnt_q[i]) begin
                wait_d[i] = (wait_q[i] == MAX_W) ? wait_q[i] : wait_q[i] + 1'b1;
            end
            starve[i] = (wait_q[i] == MAX_W);
        end
        starve_rise  = starve & ~starve_prev_q;
        starve_cnt_d = starve_cnt_q;
        if ((|starve_rise) && (starve_cnt_q != '1)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            gnt_vld_q     <= 1'b0;
            ptr_q         <= LAST_IDX;
            starve_prev_q <= '0;
            starve_cnt_q  <= '0;
            for (int i = 0; i < N; i++) wait_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            gnt_vld_q     <= |gnt_d;
            ptr_q         <= ptr_d;
            starve_prev_q <= starve;
            starve_cnt_q  <= starve_cnt_d;
            for (int i = 0; i < N; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_vld    = gnt_vld_q;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.starve     = starve;
    assign bus.starve_cnt = starve_cnt_q;

`ifdef ARB_ASSERT_EN
    logic [N-1:0] req_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_prev_q <= '0;
        else     req_prev_q <= bus.req;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt_q))
            else $error("%m: grant not one-hot-or-zero: gnt=%b", gnt_q);
            assert ((gnt_q & ~req_prev_q) == '0)
            else $error("%m: grant without prior request: gnt=%b req=%b", gnt_q, req_prev_q);
            for (int i = 0; i < N; i++) begin
                if (starve_rise[i]) $warning("%m: requester %0d starving", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_arb_chk.sv
// Directed self-checking bench for rr_arb_chk. Two instances: the default
// build (N=4, MAX_WAIT=15, CNT_W=8) and a narrow-counter build
// (N=4, MAX_WAIT=3, CNT_W=2) for saturation.
module tb_rr_arb_chk;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    rr_arb_chk_if #(.N(4), .CNT_W(8)) bus0 ();
    rr_arb_chk_if #(.N(4), .CNT_W(2)) bus1 ();

    rr_arb_chk #(.N(4), .MAX_WAIT(15), .CNT_W(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    rr_arb_chk #(.N(4), .MAX_WAIT(3), .CNT_W(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    // One rising edge passes; returns at the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus0.req = '0;
        bus1.req = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (bus0.gnt !== 4'b0000 || bus0.gnt_vld !== 1'b0 || bus0.gnt_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_gnt: gnt=%b vld=%b id=%0d, want 0000/0/0",
                     bus0.gnt, bus0.gnt_vld, bus0.gnt_id);
        end
        tests++;
        if (bus0.starve !== 4'b0000 || bus0.starve_cnt !== 8'd0 || bus1.starve_cnt !== 2'd0) begin
            fails++;
            $display("FAIL reset_starve: starve=%b cnt0=%0d cnt1=%0d, want 0/0/0",
                     bus0.starve, bus0.starve_cnt, bus1.starve_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus0.req = 4'b0100;
        step();
        tests++;
        if (bus0.gnt !== 4'b0100 || bus0.gnt_id !== 2'd2 || bus0.gnt_vld !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: gnt=%b id=%0d vld=%b, want 0100/2/1",
                     bus0.gnt, bus0.gnt_id, bus0.gnt_vld);
        end
        step();
        step();
        tests++;
        if (bus0.gnt !== 4'b0100) begin
            fails++;
            $display("FAIL single_hold: gnt=%b, want 0100", bus0.gnt);
        end
        bus0.req = 4'b0000;
        step();
        tests++;
        if (bus0.gnt !== 4'b0000 || bus0.gnt_vld !== 1'b0 || bus0.gnt_id !== 2'd0) begin
            fails++;
            $display("FAIL single_release: gnt=%b vld=%b id=%0d, want 0000/0/0",
                     bus0.gnt, bus0.gnt_vld, bus0.gnt_id);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] r;
        logic [3:0] exp;
        do_reset();
        bus0.req = 4'b1111;
        step();
        tests++;
        if (bus0.gnt !== 4'b0001 || bus0.gnt_id !== 2'd0) begin
            fails++;
            $display("FAIL rot_first: gnt=%b id=%0d, want 0001/0", bus0.gnt, bus0.gnt_id);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            step();
            r = 4'b1111;
            r[(k - 1) % 4] = 1'b0;
            bus0.req = r;
            step();
            exp = 4'b0001 << (k % 4);
            tests++;
            if (bus0.gnt !== exp || bus0.gnt_id !== 2'(k % 4) || bus0.gnt_vld !== 1'b1) begin
                fails++;
                $display("FAIL rot_handover%0d: gnt=%b id=%0d vld=%b, want %b/%0d/1",
                         k, bus0.gnt, bus0.gnt_id, bus0.gnt_vld, exp, k % 4);
            end
            bus0.req = 4'b1111;
        end
    endtask

    task automatic test_starvation();
        do_reset();
        bus0.req = 4'b1001;
        repeat (14) step();
        tests++;
        if (bus0.starve !== 4'b0000 || bus0.gnt !== 4'b0001) begin
            fails++;
            $display("FAIL starve_early: starve=%b gnt=%b, want 0000/0001",
                     bus0.starve, bus0.gnt);
        end
        step();
        tests++;
        if (bus0.starve !== 4'b1000 || bus0.starve_cnt !== 8'd0) begin
            fails++;
            $display("FAIL starve_rise: starve=%b cnt=%0d, want 1000/0",
                     bus0.starve, bus0.starve_cnt);
        end
        step();
        tests++;
        if (bus0.starve_cnt !== 8'd1 || bus0.starve !== 4'b1000) begin
            fails++;
            $display("FAIL starve_count: starve=%b cnt=%0d, want 1000/1",
                     bus0.starve, bus0.starve_cnt);
        end
        bus0.req = 4'b0001;
        step();
        tests++;
        if (bus0.starve !== 4'b0000 || bus0.starve_cnt !== 8'd1) begin
            fails++;
            $display("FAIL starve_clear: starve=%b cnt=%0d, want 0000/1",
                     bus0.starve, bus0.starve_cnt);
        end
    endtask

    task automatic test_cnt_saturation();
        logic [1:0] exp;
        do_reset();
        bus1.req = 4'b0001;
        step();
        for (int e = 1; e <= 5; e++) begin
            bus1.req = 4'b0011;
            repeat (3) step();
            tests++;
            if (bus1.starve !== 4'b0010) begin
                fails++;
                $display("FAIL sat_starve%0d: starve=%b, want 0010", e, bus1.starve);
            end
            repeat (2) step();
            bus1.req = 4'b0001;
            repeat (2) step();
            exp = (e > 3) ? 2'd3 : 2'(e);
            tests++;
            if (bus1.starve_cnt !== exp) begin
                fails++;
                $display("FAIL sat_count%0d: cnt=%0d, want %0d", e, bus1.starve_cnt, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus0.req = 4'b0010;
        step();
        tests++;
        if (bus0.gnt !== 4'b0010) begin
            fails++;
            $display("FAIL areset_pre: gnt=%b, want 0010", bus0.gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (bus0.gnt !== 4'b0000 || bus0.gnt_vld !== 1'b0 || bus0.gnt_id !== 2'd0) begin
            fails++;
            $display("FAIL areset_clear: gnt=%b vld=%b id=%0d, want 0000/0/0",
                     bus0.gnt, bus0.gnt_vld, bus0.gnt_id);
        end
        bus0.req = 4'b1010;
        step();
        rst = 1'b0;
        step();
        tests++;
        if (bus0.gnt !== 4'b0010 || bus0.gnt_id !== 2'd1) begin
            fails++;
            $display("FAIL areset_first: gnt=%b id=%0d, want 0010/1", bus0.gnt, bus0.gnt_id);
        end
    endtask

    task automatic test_forgotten();
        do_reset();
        bus0.req = 4'b0001;
        step();
        bus0.req = 4'b0101;
        step();
        bus0.req = 4'b0000;
        step();
        tests++;
        if (bus0.gnt !== 4'b0000 || bus0.gnt_vld !== 1'b0) begin
            fails++;
            $display("FAIL forgotten: gnt=%b vld=%b, want 0000/0", bus0.gnt, bus0.gnt_vld);
        end
    endtask

    initial begin
        bus0.req = '0;
        bus1.req = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_starvation();
        test_cnt_saturation();
        test_async_reset();
        test_forgotten();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
